vector_line_gen: RTL and testbench
==================================

// Module: vector_line_gen
// PURPOSE
//  Upstream stage of the MCP4922 triple-DAC serialiser. Accepts vector commands (draw/move to an endpoint, with
//  RGB+intensity) and steps the beam along the line using integer Bresenham, one point per DAC frame tick.
//  Drives the serialiser's six 12-bit DAC values and their one-cycle latch strobes. Blanks colour on moves/dwell.
// PARAMETERS
//  STEP_DIV    37  clocks per beam step; matches the serialiser's 37-clock DAC update frame
//  DWELL_DRAW  4   blanked ticks held at the endpoint after a draw (beam settle)
//  DWELL_MOVE  8   blanked ticks held at the endpoint after a move (deflection settle)
//  X_RESET     12'h800  beam X after reset (screen centre)
//  Y_RESET     12'h800  beam Y after reset
// PORTS
//  clock          in   1   single clock, same domain as the serialiser
//  reset_n        in   1   asynchronous, active-low reset
//  cmd_valid      in   1   command present
//  cmd_ready      out  1   high only in IDLE; a command transfers on cmd_valid & cmd_ready
//  cmd_draw       in   1   1 = draw line with colour, 0 = blanked move
//  cmd_x, cmd_y   in   12  endpoint, unsigned
//  cmd_r/g/b/i    in   12  colour and intensity for a draw (ignored for a move)
//  busy           out  1   ~cmd_ready
//  dac_x..dac_i   out  12  six DAC channel values (x,y,r,g,b,i)
//  dac_x_latch..dac_i_latch out 1 one-cycle strobes, all six pulse together
// BEHAVIOUR
//  Reset: state IDLE; position=(X_RESET,Y_RESET); dac_x/y = reset position; dac_r/g/b/i=0; all latches 0;
//   cmd_ready=1 once reset released; tick counter=0. Asserting reset mid-line aborts at once, no final frame.
//  Tick: free-running counter 0..STEP_DIV-1, tick=1 when count==STEP_DIV-1; runs in every state.
//  States: IDLE -> SETUP (on transfer; latch endpoint, colour, draw flag) -> STEP or JUMP -> DWELL -> IDLE.
//  SETUP (1 cycle): dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1/-1 by sign, err=dx+dy. 14-bit signed err, 15-bit e2;
//   all differences computed at 13 bits signed, so no wrap across 0/4095.
//  STEP (draw): on each tick, register dac_x/y=current point, colour=cmd colour, pulse all six latches.
//   If point==endpoint -> DWELL, dwell count=DWELL_DRAW. Otherwise e2=2*err:
//   if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy}. Both updates may apply in one step.
//   A draw emits max(|dx|,|dy|)+1 points; a zero-length draw emits exactly one lit dot.
//  JUMP (move): on the next tick, emit the endpoint with colour 0 and latch; -> DWELL, count=DWELL_MOVE.
//  DWELL: on each tick, emit the endpoint with colour 0 and latch; decrement; after last tick -> IDLE.
//  IDLE: no latches; dac_* outputs hold. cmd_valid with cmd_ready low is not consumed; payload may change.
//  Outputs and latches are registered. Values change only on the edge where the latch pulse rises, so they are
//   stable >= STEP_DIV clocks. The first point is emitted on the first tick at least 2 clocks after the transfer.
//  Current position persists between commands; the next line starts at the previous endpoint.
// STRUCTURE
//  vector_defs.vh: state encodings, COORD_W=12, ERR_W=14, reset position defaults.
//  One sub-module vec_line_step: combinational Bresenham update (x,y,err,dx,dy,sx,sy -> next x,y,err, at_end).
//  Tick counter, FSM and output registers live in vector_line_gen.
// TESTING
//  Reset: hold reset_n low -> dac_x=dac_y=0x800, colours 0, no latches; release -> cmd_ready=1.
//  Move from centre to (0,0): one latch frame x=0,y=0,rgbi=0, then 8 blanked frames, then cmd_ready=1.
//  Draw (0,0)->(3,0), rgbi=0xFFF: frames x=0,1,2,3, y=0, lit, STEP_DIV clocks apart; then 4 blanked frames at (3,0).
//  Steep draw (0,0)->(1,3): lit points (0,0),(0,1),(1,2),(1,3) exactly; dwell at (1,3).
//  Edge/negative: at (4095,4095), draw to (4093,4095) -> x=4095,4094,4093, no wrap. Zero-length draw -> one lit dot.
//  Assert reset_n mid-line at point 2 of 5 -> no further latches, outputs at reset values; a new cmd after release
//   starts from (0x800,0x800). cmd_valid held high while busy -> accepted only after DWELL ends.

Source files
------------

// File: rtl/vector_line_gen_pkg.sv
// Shared widths, default timing/position constants and FSM encoding for the
// vector line generator feeding the MCP4922 DAC serialiser.
package vector_line_gen_pkg;

    localparam int COORD_W = 12;
    localparam int DIFF_W  = 13;
    localparam int ERR_W   = 14;
    localparam int E2_W    = 15;
    localparam int CNT_W   = 6;
    localparam int DWELL_W = 4;

    localparam int STEP_DIV_DEF   = 37;
    localparam int DWELL_DRAW_DEF = 4;
    localparam int DWELL_MOVE_DEF = 8;

    localparam logic [COORD_W-1:0] X_RESET_DEF = 12'h800;
    localparam logic [COORD_W-1:0] Y_RESET_DEF = 12'h800;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_STEP  = 3'd2,
        ST_JUMP  = 3'd3,
        ST_DWELL = 3'd4
    } state_e;

    function automatic logic signed [DIFF_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] v);
        return v[DIFF_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/vector_line_gen_step.sv
// Combinational Bresenham update: one step of the current point towards the
// endpoint, plus the at-endpoint flag.
module vector_line_gen_step
    import vector_line_gen_pkg::*;
(
    input  logic [COORD_W-1:0]       i_x,
    input  logic [COORD_W-1:0]       i_y,
    input  logic [COORD_W-1:0]       i_x1,
    input  logic [COORD_W-1:0]       i_y1,
    input  logic signed [ERR_W-1:0]  i_err,
    input  logic signed [DIFF_W-1:0] i_dx,
    input  logic signed [DIFF_W-1:0] i_dy,
    input  logic                     i_sx_neg,
    input  logic                     i_sy_neg,
    output logic [COORD_W-1:0]       o_x,
    output logic [COORD_W-1:0]       o_y,
    output logic signed [ERR_W-1:0]  o_err,
    output logic                     o_at_end
);

    logic signed [E2_W-1:0]  w_e2;
    logic signed [E2_W-1:0]  w_dx_e2;
    logic signed [E2_W-1:0]  w_dy_e2;
    logic signed [ERR_W-1:0] w_dx_err;
    logic signed [ERR_W-1:0] w_dy_err;
    logic signed [ERR_W-1:0] w_err_a;

    // Bresenham point/error update; both axes may advance in the same step.
    always_comb begin
        w_e2     = {i_err, 1'b0};
        w_dx_e2  = {{2{i_dx[DIFF_W-1]}}, i_dx};
        w_dy_e2  = {{2{i_dy[DIFF_W-1]}}, i_dy};
        w_dx_err = {i_dx[DIFF_W-1], i_dx};
        w_dy_err = {i_dy[DIFF_W-1], i_dy};
        o_x      = i_x;
        o_y      = i_y;
        o_at_end = (i_x == i_x1) && (i_y == i_y1);

        if (w_e2 >= w_dy_e2) begin
            w_err_a = i_err + w_dy_err;
            o_x     = i_sx_neg ? (i_x - 12'd1) : (i_x + 12'd1);
        end else begin
            w_err_a = i_err;
        end

        if (w_e2 <= w_dx_e2) begin
            o_err = w_err_a + w_dx_err;
            o_y   = i_sy_neg ? (i_y - 12'd1) : (i_y + 12'd1);
        end else begin
            o_err = w_err_a;
        end
    end

endmodule

// File: rtl/vector_line_gen.sv
// Vector command front end: accepts draw/move commands and emits one DAC frame
// per beam tick (every STEP_DIV clocks) with all six channel latches pulsing together.
module vector_line_gen
    import vector_line_gen_pkg::*;
#(
    parameter int                 STEP_DIV   = STEP_DIV_DEF,
    parameter int                 DWELL_DRAW = DWELL_DRAW_DEF,
    parameter int                 DWELL_MOVE = DWELL_MOVE_DEF,
    parameter logic [COORD_W-1:0] X_RESET    = X_RESET_DEF,
    parameter logic [COORD_W-1:0] Y_RESET    = Y_RESET_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_draw,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [COORD_W-1:0] cmd_r,
    input  logic [COORD_W-1:0] cmd_g,
    input  logic [COORD_W-1:0] cmd_b,
    input  logic [COORD_W-1:0] cmd_i,
    output logic               busy,
    output logic [COORD_W-1:0] dac_x,
    output logic [COORD_W-1:0] dac_y,
    output logic [COORD_W-1:0] dac_r,
    output logic [COORD_W-1:0] dac_g,
    output logic [COORD_W-1:0] dac_b,
    output logic [COORD_W-1:0] dac_i,
    output logic               dac_x_latch,
    output logic               dac_y_latch,
    output logic               dac_r_latch,
    output logic               dac_g_latch,
    output logic               dac_b_latch,
    output logic               dac_i_latch
);

    state_e r_state;
    state_e w_next;

    logic [CNT_W-1:0]         r_cnt;
    logic                     w_tick;
    logic [COORD_W-1:0]       r_x, r_y, r_x1, r_y1;
    logic [COORD_W-1:0]       r_col_r, r_col_g, r_col_b, r_col_i;
    logic                     r_draw;
    logic signed [DIFF_W-1:0] r_dx, r_dy;
    logic signed [ERR_W-1:0]  r_err;
    logic                     r_sx_neg, r_sy_neg;
    logic [DWELL_W-1:0]       r_dwell;
    logic [COORD_W-1:0]       r_dac_x, r_dac_y, r_dac_r, r_dac_g, r_dac_b, r_dac_i;
    logic                     r_latch;
    logic                     r_ready;

    logic signed [DIFF_W-1:0] w_diff_x, w_diff_y, w_adx, w_ady;
    logic [COORD_W-1:0]       w_nx, w_ny;
    logic signed [ERR_W-1:0]  w_nerr;
    logic                     w_at_end;

    assign w_tick   = (r_cnt == CNT_W'(STEP_DIV - 1));
    // Differences at 13 bits signed so lines never wrap across 0/4095.
    assign w_diff_x = $signed({1'b0, r_x1}) - $signed({1'b0, r_x});
    assign w_diff_y = $signed({1'b0, r_y1}) - $signed({1'b0, r_y});
    assign w_adx    = abs_diff(w_diff_x);
    assign w_ady    = abs_diff(w_diff_y);

    vector_line_gen_step u_step (
        .i_x      (r_x),
        .i_y      (r_y),
        .i_x1     (r_x1),
        .i_y1     (r_y1),
        .i_err    (r_err),
        .i_dx     (r_dx),
        .i_dy     (r_dy),
        .i_sx_neg (r_sx_neg),
        .i_sy_neg (r_sy_neg),
        .o_x      (w_nx),
        .o_y      (w_ny),
        .o_err    (w_nerr),
        .o_at_end (w_at_end)
    );

    // Free-running beam tick divider, active in every state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = cmd_valid ? ST_SETUP : ST_IDLE;
            ST_SETUP: w_next = r_draw ? ST_STEP : ST_JUMP;
            ST_STEP:  w_next = (w_tick && w_at_end) ? ST_DWELL : ST_STEP;
            ST_JUMP:  w_next = w_tick ? ST_DWELL : ST_JUMP;
            ST_DWELL: w_next = (w_tick && (r_dwell == 4'd1)) ? ST_IDLE : ST_DWELL;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Command capture, line setup, beam position and registered DAC frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x      <= X_RESET;
            r_y      <= Y_RESET;
            r_x1     <= X_RESET;
            r_y1     <= Y_RESET;
            r_col_r  <= '0;
            r_col_g  <= '0;
            r_col_b  <= '0;
            r_col_i  <= '0;
            r_draw   <= 1'b0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_dwell  <= '0;
            r_dac_x  <= X_RESET;
            r_dac_y  <= Y_RESET;
            r_dac_r  <= '0;
            r_dac_g  <= '0;
            r_dac_b  <= '0;
            r_dac_i  <= '0;
            r_latch  <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_latch <= 1'b0;
            r_ready <= (w_next == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_x1    <= cmd_x;
                        r_y1    <= cmd_y;
                        r_col_r <= cmd_r;
                        r_col_g <= cmd_g;
                        r_col_b <= cmd_b;
                        r_col_i <= cmd_i;
                        r_draw  <= cmd_draw;
                    end
                end
                ST_SETUP: begin
                    r_dx     <= w_adx;
                    r_dy     <= -w_ady;
                    r_sx_neg <= w_diff_x[DIFF_W-1];
                    r_sy_neg <= w_diff_y[DIFF_W-1];
                    r_err    <= {w_adx[DIFF_W-1], w_adx} - {w_ady[DIFF_W-1], w_ady};
                end
                ST_STEP: begin
                    if (w_tick) begin
                        r_dac_x <= r_x;
                        r_dac_y <= r_y;
                        r_dac_r <= r_col_r;
                        r_dac_g <= r_col_g;
                        r_dac_b <= r_col_b;
                        r_dac_i <= r_col_i;
                        r_latch <= 1'b1;
                        if (w_at_end) begin
                            r_dwell <= DWELL_W'(DWELL_DRAW);
                        end else begin
                            r_x   <= w_nx;
                            r_y   <= w_ny;
                            r_err <= w_nerr;
                        end
                    end
                end
                ST_JUMP: begin
                    if (w_tick) begin
                        r_x     <= r_x1;
                        r_y     <= r_y1;
                        r_dac_x <= r_x1;
                        r_dac_y <= r_y1;
                        r_dac_r <= '0;
                        r_dac_g <= '0;
                        r_dac_b <= '0;
                        r_dac_i <= '0;
                        r_latch <= 1'b1;
                        r_dwell <= DWELL_W'(DWELL_MOVE);
                    end
                end
                ST_DWELL: begin
                    if (w_tick) begin
                        r_dac_x <= r_x;
                        r_dac_y <= r_y;
                        r_dac_r <= '0;
                        r_dac_g <= '0;
                        r_dac_b <= '0;
                        r_dac_i <= '0;
                        r_latch <= 1'b1;
                        r_dwell <= r_dwell - 4'd1;
                    end
                end
                default: begin
                    r_latch <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = r_ready;
    assign busy        = ~r_ready;
    assign dac_x       = r_dac_x;
    assign dac_y       = r_dac_y;
    assign dac_r       = r_dac_r;
    assign dac_g       = r_dac_g;
    assign dac_b       = r_dac_b;
    assign dac_i       = r_dac_i;
    assign dac_x_latch = r_latch;
    assign dac_y_latch = r_latch;
    assign dac_r_latch = r_latch;
    assign dac_g_latch = r_latch;
    assign dac_b_latch = r_latch;
    assign dac_i_latch = r_latch;

endmodule

// File: tb/tb_vector_line_gen.sv
// Scoreboard bench for vector_line_gen: expected DAC frames are queued when a
// command is driven and compared as each latch pulse appears.
module tb_vector_line_gen;

    localparam int STEP_DIV   = 37;
    localparam int DWELL_DRAW = 4;
    localparam int DWELL_MOVE = 8;

    typedef struct packed {
        logic [11:0] x, y, r, g, b, i;
    } frame_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready, busy;
    logic        cmd_draw = 1'b0;
    logic [11:0] cmd_x = 12'd0, cmd_y = 12'd0;
    logic [11:0] cmd_r = 12'd0, cmd_g = 12'd0, cmd_b = 12'd0, cmd_i = 12'd0;
    logic [11:0] dac_x, dac_y, dac_r, dac_g, dac_b, dac_i;
    logic        dac_x_latch, dac_y_latch, dac_r_latch, dac_g_latch, dac_b_latch, dac_i_latch;

    frame_t exp_q[$];
    frame_t held = {12'h800, 12'h800, 12'd0, 12'd0, 12'd0, 12'd0};
    frame_t rst_frame = {12'h800, 12'h800, 12'd0, 12'd0, 12'd0, 12'd0};
    int n_vec = 0;
    int n_miss = 0;
    int m_x = 'h800;
    int m_y = 'h800;
    int cyc = 0;
    int last_latch = -1;

    vector_line_gen dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_draw(cmd_draw),
        .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b), .cmd_i(cmd_i),
        .busy(busy),
        .dac_x(dac_x), .dac_y(dac_y), .dac_r(dac_r), .dac_g(dac_g), .dac_b(dac_b), .dac_i(dac_i),
        .dac_x_latch(dac_x_latch), .dac_y_latch(dac_y_latch), .dac_r_latch(dac_r_latch),
        .dac_g_latch(dac_g_latch), .dac_b_latch(dac_b_latch), .dac_i_latch(dac_i_latch)
    );

    always #5 clock = ~clock;

    // Monitor: pop and compare on latch frames, check holding and reset values otherwise.
    always @(negedge clock) begin
        frame_t act;
        frame_t e;
        logic [5:0] lat;
        cyc++;
        act = {dac_x, dac_y, dac_r, dac_g, dac_b, dac_i};
        lat = {dac_x_latch, dac_y_latch, dac_r_latch, dac_g_latch, dac_b_latch, dac_i_latch};
        if (!reset_n) begin
            n_vec++;
            if (lat !== 6'b0 || act !== rst_frame) begin
                n_miss++;
                $display("FAIL reset_hold: got latches=%b x=%h y=%h rgbi=%h/%h/%h/%h, expected latches=000000 x=800 y=800 rgbi=0",
                         lat, act.x, act.y, act.r, act.g, act.b, act.i);
            end
            held = rst_frame;
            last_latch = -1;
        end else if (lat !== 6'b0) begin
            n_vec++;
            if (lat !== 6'b111111) begin
                n_miss++;
                $display("FAIL latch_group: got %b, expected 111111", lat);
            end
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_frame: got x=%0d y=%0d, expected no frame", act.x, act.y);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_miss++;
                    $display("FAIL frame: got x=%0d y=%0d rgbi=%h/%h/%h/%h, expected x=%0d y=%0d rgbi=%h/%h/%h/%h",
                             act.x, act.y, act.r, act.g, act.b, act.i, e.x, e.y, e.r, e.g, e.b, e.i);
                end
            end
            if (last_latch >= 0 && ((cyc - last_latch) % STEP_DIV) != 0) begin
                n_miss++;
                $display("FAIL frame_spacing: got %0d clocks, expected multiple of %0d", cyc - last_latch, STEP_DIV);
            end
            last_latch = cyc;
            held = act;
        end else begin
            n_vec++;
            if (act !== held) begin
                n_miss++;
                $display("FAIL output_hold: got x=%h y=%h rgbi=%h/%h/%h/%h, expected x=%h y=%h rgbi=%h/%h/%h/%h",
                         act.x, act.y, act.r, act.g, act.b, act.i, held.x, held.y, held.r, held.g, held.b, held.i);
            end
        end
    end

    function automatic void push_f(input int x, input int y, input logic [11:0] r, g, b, i);
        frame_t f;
        f.x = 12'(x); f.y = 12'(y); f.r = r; f.g = g; f.b = b; f.i = i;
        exp_q.push_back(f);
    endfunction

    // Reference integer Bresenham plus dwell frames; updates the model position.
    task automatic model_cmd(input logic d, input int x1, input int y1, input logic [11:0] r, g, b, i);
        int x, y, dx, dy, sx, sy, err, e2;
        if (!d) begin
            for (int k = 0; k <= DWELL_MOVE; k++) push_f(x1, y1, 12'd0, 12'd0, 12'd0, 12'd0);
        end else begin
            x = m_x; y = m_y;
            dx = (x1 > x) ? (x1 - x) : (x - x1);
            dy = (y1 > y) ? (y - y1) : (y1 - y);
            sx = (x1 >= x) ? 1 : -1;
            sy = (y1 >= y) ? 1 : -1;
            err = dx + dy;
            for (int k = 0; k < 8192; k++) begin
                push_f(x, y, r, g, b, i);
                if (x == x1 && y == y1) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
            end
            for (int k = 0; k < DWELL_DRAW; k++) push_f(x1, y1, 12'd0, 12'd0, 12'd0, 12'd0);
        end
        m_x = x1; m_y = y1;
    endtask

    task automatic send_cmd(input logic d, input int x, input int y, input logic [11:0] r, g, b, i);
        logic rdy;
        logic accepted;
        accepted = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_draw = d; cmd_x = 12'(x); cmd_y = 12'(y);
        cmd_r = r; cmd_g = g; cmd_b = b; cmd_i = i;
        for (int k = 0; k < 5000 && !accepted; k++) begin
            rdy = cmd_ready;
            @(posedge clock);
            accepted = rdy;
            #1;
        end
        cmd_valid = 1'b0;
        cmd_x = 12'($urandom);
        cmd_r = 12'($urandom);
        n_vec++;
        if (!accepted) begin
            n_miss++;
            $display("FAIL send_timeout: got no transfer, expected cmd_ready within 5000 clocks");
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 4000; k++) begin
            @(negedge clock);
            #1;
            if (cmd_ready) break;
        end
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL idle_timeout: got cmd_ready=%b, expected 1", cmd_ready);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL frames_missing: got %0d frames outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic do_cmd(input logic d, input int x1, input int y1, input logic [11:0] r, g, b, i);
        model_cmd(d, x1, y1, r, g, b, i);
        send_cmd(d, x1, y1, r, g, b, i);
        wait_idle();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        n_vec++;
        if ({dac_x, dac_y} !== {12'h800, 12'h800} || {dac_r, dac_g, dac_b, dac_i} !== 48'd0) begin
            n_miss++;
            $display("FAIL reset_values: got x=%h y=%h rgbi=%h/%h/%h/%h, expected 800/800/0", dac_x, dac_y, dac_r, dac_g, dac_b, dac_i);
        end
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_ready: got cmd_ready=%b busy=%b, expected 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_move();
        for (int k = 0; k <= DWELL_MOVE; k++) push_f(0, 0, 12'd0, 12'd0, 12'd0, 12'd0);
        send_cmd(1'b0, 0, 0, 12'hABC, 12'h123, 12'h456, 12'h789);
        wait_idle();
        m_x = 0; m_y = 0;
    endtask

    task automatic test_draw_horizontal();
        for (int k = 0; k < 4; k++) push_f(k, 0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        for (int k = 0; k < DWELL_DRAW; k++) push_f(3, 0, 12'd0, 12'd0, 12'd0, 12'd0);
        send_cmd(1'b1, 3, 0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        wait_idle();
        m_x = 3; m_y = 0;
    endtask

    task automatic test_draw_steep();
        do_cmd(1'b0, 0, 0, 12'd0, 12'd0, 12'd0, 12'd0);
        push_f(0, 0, 12'h111, 12'h222, 12'h333, 12'h444);
        push_f(0, 1, 12'h111, 12'h222, 12'h333, 12'h444);
        push_f(1, 2, 12'h111, 12'h222, 12'h333, 12'h444);
        push_f(1, 3, 12'h111, 12'h222, 12'h333, 12'h444);
        for (int k = 0; k < DWELL_DRAW; k++) push_f(1, 3, 12'd0, 12'd0, 12'd0, 12'd0);
        send_cmd(1'b1, 1, 3, 12'h111, 12'h222, 12'h333, 12'h444);
        wait_idle();
        m_x = 1; m_y = 3;
    endtask

    task automatic test_edge_and_zero();
        do_cmd(1'b0, 4095, 4095, 12'd0, 12'd0, 12'd0, 12'd0);
        push_f(4095, 4095, 12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0);
        push_f(4094, 4095, 12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0);
        push_f(4093, 4095, 12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0);
        for (int k = 0; k < DWELL_DRAW; k++) push_f(4093, 4095, 12'd0, 12'd0, 12'd0, 12'd0);
        send_cmd(1'b1, 4093, 4095, 12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0);
        wait_idle();
        push_f(4093, 4095, 12'h5A5, 12'hA5A, 12'h0F0, 12'hF0F);
        for (int k = 0; k < DWELL_DRAW; k++) push_f(4093, 4095, 12'd0, 12'd0, 12'd0, 12'd0);
        send_cmd(1'b1, 4093, 4095, 12'h5A5, 12'hA5A, 12'h0F0, 12'hF0F);
        wait_idle();
        m_x = 4093; m_y = 4095;
    endtask

    task automatic test_random_lines();
        int nx, ny;
        do_cmd(1'b0, 1000, 2000, 12'd0, 12'd0, 12'd0, 12'd0);
        for (int k = 0; k < 5; k++) begin
            nx = m_x + int'($urandom_range(30)) - 15;
            ny = m_y + int'($urandom_range(30)) - 15;
            do_cmd(1'b1, nx, ny, 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        int before_b, nb, qsz;
        logic rdy, accepted;
        model_cmd(1'b1, m_x + 4, m_y - 2, 12'h321, 12'h654, 12'h987, 12'hCBA);
        send_cmd(1'b1, m_x, m_y, 12'h321, 12'h654, 12'h987, 12'hCBA);
        n_vec++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL busy_after_transfer: got busy=%b cmd_ready=%b, expected 1/0", busy, cmd_ready);
        end
        before_b = exp_q.size();
        model_cmd(1'b0, 200, 300, 12'd0, 12'd0, 12'd0, 12'd0);
        nb = exp_q.size() - before_b;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_draw = 1'b0; cmd_x = 12'd200; cmd_y = 12'd300;
        accepted = 1'b0;
        qsz = -1;
        for (int k = 0; k < 5000 && !accepted; k++) begin
            rdy = cmd_ready;
            @(posedge clock);
            accepted = rdy;
            if (rdy) qsz = exp_q.size();
            #1;
        end
        cmd_valid = 1'b0;
        n_vec++;
        if (qsz != nb) begin
            n_miss++;
            $display("FAIL accept_while_busy: got %0d frames queued at transfer, expected %0d", qsz, nb);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_line();
        do_cmd(1'b0, 0, 0, 12'd0, 12'd0, 12'd0, 12'd0);
        model_cmd(1'b1, 4, 0, 12'h777, 12'h777, 12'h777, 12'h777);
        send_cmd(1'b1, 4, 0, 12'h777, 12'h777, 12'h777, 12'h777);
        for (int k = 0; k < 2000 && exp_q.size() > 7; k++) begin
            @(negedge clock);
            #1;
        end
        n_vec++;
        if (exp_q.size() != 7) begin
            n_miss++;
            $display("FAIL mid_line_progress: got %0d frames outstanding, expected 7", exp_q.size());
        end
        reset_n = 1'b0;
        exp_q.delete();
        repeat (100) @(negedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1 || dac_x !== 12'h800 || dac_y !== 12'h800) begin
            n_miss++;
            $display("FAIL post_abort: got cmd_ready=%b x=%h y=%h, expected 1/800/800", cmd_ready, dac_x, dac_y);
        end
        m_x = 'h800; m_y = 'h800;
        do_cmd(1'b1, 'h803, 'h7FE, 12'h00F, 12'h0F0, 12'hF00, 12'hFFF);
    endtask

    initial begin
        test_reset();
        test_move();
        test_draw_horizontal();
        test_draw_steep();
        test_edge_and_zero();
        test_random_lines();
        test_back_to_back();
        test_reset_mid_line();
        repeat (80) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
